// File: rtl/polar_pkg.sv
// polar_pkg
//   Shared constants, FSM state type and trig-fold helpers for polar_reassemble.
//   DATA_W/TRIG_W : signed widths of magnitude and trig operands
//   ROM_AW        : quarter-wave cosine table address width
//   FRAC_SH       : Q2.16 fraction shift applied after the multiply
package polar_pkg;

    localparam int  DATA_W  = 18;
    localparam int  TRIG_W  = 18;
    localparam int  ROM_AW  = 10;
    localparam int  FRAC_SH = 16;
    localparam real PI      = 3.141592653589793;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_C = 3'd1,
        ADDR_S = 3'd2,
        MUL_R  = 3'd3,
        MUL_I  = 3'd4,
        OUT    = 3'd5
    } state_t;

    // Table index for cos or sin. The table holds cos over the first quarter
    // wave; the second quarter of cos and the first quarter of sin both read
    // it mirrored (~k).
    function automatic logic [ROM_AW-1:0] fold_idx(input logic h,
                                                   input logic [ROM_AW-1:0] k,
                                                   input logic is_sin);
        return (h ^ is_sin) ? ~k : k;
    endfunction

    // Turn an unsigned table value into a signed trig operand.
    function automatic logic signed [TRIG_W-1:0] apply_sign(input logic [15:0] mag,
                                                           input logic neg);
        logic signed [TRIG_W-1:0] v;
        v = $signed({{(TRIG_W-16){1'b0}}, mag});
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/polar_reassemble_rom.sv
// quarter_cos_rom
//   Registered quarter-wave cosine table:
//   C(k) = round(cos((k+0.5)*pi/(2*DEPTH)) * 65535), k = 0..DEPTH-1.
//   The contents are generated at elaboration from the formula, so no
//   external memory-init file has to track the parameters.
//   clk  : clock, rising edge
//   addr : table index, sampled every edge
//   q    : C(addr) one cycle later
module quarter_cos_rom
    import polar_pkg::*;
#(
    parameter int AW = ROM_AW
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [15:0]   q
);

    localparam int DEPTH = 1 << AW;

    typedef logic [DEPTH-1:0][15:0] table_t;

    // Split into two short loops so elaboration-time evaluation stays cheap.
    function automatic table_t gen_table();
        table_t t;
        real    x;
        t = '0;
        for (int hi = 0; hi < DEPTH / 32; hi++) begin
            for (int lo = 0; lo < 32; lo++) begin
                x = $cos((real'(hi * 32 + lo) + 0.5) * PI / real'(2 * DEPTH)) * 65535.0;
                t[hi * 32 + lo] = 16'($rtoi(x + 0.5));
            end
        end
        return t;
    endfunction

    localparam table_t TABLE = gen_table();

    always_ff @(posedge clk) begin
        q <= TABLE[addr];
    end

endmodule

// File: rtl/polar_reassemble.sv
// polar_reassemble
//   Magnitude/phase -> rectangular: r = abs*cos(th), i = abs*sin(th).
//   One registered cosine ROM and one shared 18x18 multiplier, sequenced by
//   a six-state FSM; one sample in flight, 6 cycles per sample.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for abs_in/ph_in
//   abs_in              : signed magnitude, Q2.16
//   ph_in               : [17] imaginary sign, [16:0] th in units of pi/2^17
//   out_valid/out_ready : output handshake for r_out/i_out
//   r_out, i_out        : signed Q2.16 results, truncated toward -inf
module polar_reassemble
    import polar_pkg::*;
#(
    parameter int ROM_AW = 10,
    parameter int TRIG_W = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] abs_in,
    input  logic [17:0] ph_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] r_out,
    output logic [17:0] i_out
);

    state_t                     state;
    logic signed [DATA_W-1:0]   abs_q;
    logic [17:0]                ph_q;
    logic signed [TRIG_W-1:0]   trig_c;
    logic signed [TRIG_W-1:0]   trig_s;

    logic [ROM_AW-1:0]          rom_addr;
    logic [15:0]                rom_q;
    logic signed [TRIG_W-1:0]   mul_b;
    logic signed [DATA_W+TRIG_W-1:0] prod;
    logic [17:0]                prod_q;

    assign in_ready = (state == IDLE) && !reset;

    // The ROM address only matters in ADDR_C (cos) and ADDR_S (sin); in
    // every other state the read result is simply ignored.
    assign rom_addr = fold_idx(ph_q[16], ph_q[15:6], state == ADDR_S);

    quarter_cos_rom #(.AW(ROM_AW)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .q    (rom_q)
    );

    // Single multiplier: cos operand in MUL_R, sin operand otherwise.
    assign mul_b  = (state == MUL_R) ? trig_c : trig_s;
    assign prod   = abs_q * mul_b;
    assign prod_q = prod[FRAC_SH+17:FRAC_SH];

    // Product bits above/below the Q2.16 window and the sub-index phase bits
    // are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{prod[DATA_W+TRIG_W-1:FRAC_SH+18], prod[FRAC_SH-1:0], ph_q[5:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            abs_q     <= '0;
            ph_q      <= '0;
            trig_c    <= '0;
            trig_s    <= '0;
            r_out     <= '0;
            i_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        abs_q <= $signed(abs_in);
                        ph_q  <= ph_in;
                        state <= ADDR_C;
                    end
                end
                ADDR_C: state <= ADDR_S;
                ADDR_S: begin
                    // rom_q holds the cos entry addressed in ADDR_C
                    trig_c <= apply_sign(rom_q, ph_q[16]);
                    state  <= MUL_R;
                end
                MUL_R: begin
                    r_out  <= prod_q;
                    // rom_q now holds the sin entry addressed in ADDR_S
                    trig_s <= apply_sign(rom_q, ph_q[17]);
                    state  <= MUL_I;
                end
                MUL_I: begin
                    i_out     <= prod_q;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
